fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_stage_sequencer.sv | 136 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks an in-place radix-2 FFT stage by stage, issuing one butterfly per
// cycle (operand addresses, twiddle index, first/last flags) and waiting for every butterfly of a
// stage to come back before starting the next one.
module fft_stage_sequencer #(
  parameter int unsigned FFT_N    = 10,
  parameter int unsigned PL_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hold,
  input  logic                     bfly_oact,
  output logic                     iact,
  output logic [1:0]               ictrl,
  output logic [FFT_N-1:0]         addr_a,
  output logic [FFT_N-1:0]         addr_b,
  output logic [FFT_N-2:0]         tw_addr,
  output logic [$clog2(FFT_N)-1:0] stage,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned StW = $clog2(FFT_N);
  localparam int unsigned JW  = FFT_N - 1;

  localparam logic [FFT_N-1:0] OneN    = FFT_N'(1);
  localparam logic [JW-1:0]    OneJ    = JW'(1);
  localparam logic [FFT_N-1:0] HalfN   = {1'b1, {JW{1'b0}}};
  localparam logic [StW-1:0]   LastStg = StW'(FFT_N - 1);
  localparam logic [StW-1:0]   OneS    = StW'(1);

  // Completion is detected by counting returned butterflies, so the pipeline depth never
  // enters the logic; it is kept only as documentation of the attached datapath.
  if (PL_DEPTH == 0) begin : g_no_bfly_latency
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q;
  logic [JW-1:0]    j_q;
  logic [FFT_N-1:0] ret_q;

  logic [StW-1:0]   ins_pos;
  logic [FFT_N-1:0] j_ext;
  logic [FFT_N-1:0] ins_bit;
  logic [FFT_N-1:0] low_mask;
  logic [FFT_N-1:0] addr_a_d;
  logic [FFT_N-1:0] addr_b_d;
  logic [JW-1:0]    tw_d;
  logic [1:0]       ictrl_d;
  logic [FFT_N-1:0] ret_inc;

  // Butterfly geometry for the current index: insert the pair-select bit into j at position
  // FFT_N-1-stage; the twiddle is j modulo the half-span scaled up by the stage number.
  always_comb begin
    ins_pos  = LastStg - stage;
    j_ext    = {1'b0, j_q};
    ins_bit  = OneN << ins_pos;
    low_mask = ins_bit - OneN;
    addr_a_d = ((j_ext & ~low_mask) << 1) | (j_ext & low_mask);
    addr_b_d = addr_a_d | ins_bit;
    tw_d     = (j_q & low_mask[JW-1:0]) << stage;
    ictrl_d  = {(j_q == '1), (j_q == '0)};
    ret_inc  = ret_q + {{JW{1'b0}}, bfly_oact};
  end

  // Sequencer FSM with all outputs registered; iact and done default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      j_q     <= '0;
      ret_q   <= '0;
      stage   <= '0;
      iact    <= 1'b0;
      ictrl   <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      tw_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      iact <= 1'b0;
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            busy    <= 1'b1;
            j_q     <= '0;
            ret_q   <= '0;
            stage   <= '0;
          end
        end
        StIssue: begin
          // Early returns are counted here so DRAIN only has to wait for the stragglers.
          ret_q <= ret_inc;
          if (!hold) begin
            iact    <= 1'b1;
            ictrl   <= ictrl_d;
            addr_a  <= addr_a_d;
            addr_b  <= addr_b_d;
            tw_addr <= tw_d;
            j_q     <= j_q + OneJ;
            if (j_q == '1) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (ret_inc == HalfN) begin
            ret_q <= '0;
            if (stage == LastStg) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              stage   <= stage + OneS;
              state_q <= StIssue;
            end
          end else begin
            ret_q <= ret_inc;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          stage   <= '0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: an FFT_N=3 instance driven through directed scenarios with
// a table-fed scoreboard, plus an FFT_N=10 instance checked against a grouped-butterfly model.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FFT_N = 3 instance ----------------
  logic       rst3 = 1'b1, start3 = 1'b0, hold3 = 1'b0, oact3 = 1'b0;
  logic       iact3, busy3, done3;
  logic [1:0] ictrl3, tw3, stage3;
  logic [2:0] a3, b3;

  fft_stage_sequencer #(.FFT_N(3), .PL_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .hold(hold3), .bfly_oact(oact3),
    .iact(iact3), .ictrl(ictrl3), .addr_a(a3), .addr_b(b3), .tw_addr(tw3),
    .stage(stage3), .busy(busy3), .done(done3)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] ictrl;
    logic [1:0] stage;
  } vec3_t;

  vec3_t tbl[12];
  vec3_t sb3[$];

  // Butterfly return loop: iact delayed three cycles, optionally withheld, one return per cycle.
  logic [2:0] pipe3 = '0;
  int         pend3 = 0;
  int         oact_cnt = 0;
  int         last_oact_cyc = 0;
  logic       withhold = 1'b0;
  always @(negedge clk) begin
    if (rst3) begin
      pipe3 = '0;
      pend3 = 0;
      oact3 = 1'b0;
    end else begin
      pipe3 = {pipe3[1:0], iact3};
      if (pipe3[2]) pend3++;
      oact3 = !withhold && (pend3 > 0);
      if (oact3) begin
        pend3--;
        oact_cnt++;
        last_oact_cyc = cyc;
      end
    end
  end

  // Scoreboard pop, address-hold tracking and done-pulse accounting.
  logic [2:0] la = '0, lb = '0;
  logic [1:0] lt = '0;
  logic       prev_done = 1'b0;
  int         done_cnt = 0;
  always @(negedge clk) begin
    vec3_t e;
    if (rst3) begin
      la = '0; lb = '0; lt = '0;
    end else if (iact3) begin
      if (sb3.size() == 0) begin
        check("unexpected_issue", {a3, b3, tw3, ictrl3, stage3}, 64'h0);
        n_fail += (({a3, b3, tw3, ictrl3, stage3} === 12'h0) ? 1 : 0);
      end else begin
        e = sb3.pop_front();
        check("issue_abtw_ictrl_stage", {a3, b3, tw3, ictrl3, stage3},
              {e.a, e.b, e.tw, e.ictrl, e.stage});
      end
      la = a3; lb = b3; lt = tw3;
    end else if (busy3) begin
      check("addr_hold_when_idle_issue", {a3, b3, tw3}, {la, lb, lt});
    end
    if (done3) begin
      done_cnt++;
      check("done_single_cycle", prev_done, 1'b0);
    end
    prev_done = done3;
  end

  task automatic pulse_start3();
    foreach (tbl[i]) sb3.push_back(tbl[i]);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    int base = done_cnt;
    for (int k = 0; k < 400 && done_cnt == base; k++) @(negedge clk);
    check({name, "_done_seen"}, done_cnt - base, 1);
    repeat (3) @(negedge clk);
    check({name, "_busy_dropped"}, busy3, 1'b0);
    check({name, "_all_issued"}, sb3.size(), 0);
    repeat (20) @(negedge clk);
    check({name, "_one_done"}, done_cnt - base, 1);
  endtask

  // ---------------- FFT_N = 10 instance ----------------
  logic       rst10 = 1'b1, start10 = 1'b0, oact10 = 1'b0;
  logic       iact10, busy10, done10;
  logic [1:0] ictrl10;
  logic [9:0] a10, b10;
  logic [8:0] tw10;
  logic [3:0] stage10;

  fft_stage_sequencer #(.FFT_N(10), .PL_DEPTH(3)) dut10 (
    .clk(clk), .rst(rst10), .start(start10), .hold(1'b0), .bfly_oact(oact10),
    .iact(iact10), .ictrl(ictrl10), .addr_a(a10), .addr_b(b10), .tw_addr(tw10),
    .stage(stage10), .busy(busy10), .done(done10)
  );

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [8:0] tw;
    logic [1:0] ictrl;
    logic [3:0] stage;
  } vec10_t;

  vec10_t sb10[$];
  logic [2:0] pipe10 = '0;
  int pend10 = 0, done10_cnt = 0, tw9_nonzero = 0, iss10 = 0;
  always @(negedge clk) begin
    vec10_t e;
    if (rst10) begin
      pipe10 = '0;
      pend10 = 0;
      oact10 = 1'b0;
    end else begin
      pipe10 = {pipe10[1:0], iact10};
      if (pipe10[2]) pend10++;
      oact10 = (pend10 > 0);
      if (oact10) pend10--;
      if (iact10) begin
        iss10++;
        if (stage10 == 4'd9 && tw10 != 9'd0) tw9_nonzero++;
        if (sb10.size() == 0) begin
          check("n10_unexpected_issue", iss10, 5120);
        end else begin
          e = sb10.pop_front();
          check("n10_issue", {a10, b10, tw10, ictrl10, stage10},
                {e.a, e.b, e.tw, e.ictrl, e.stage});
        end
      end
      if (done10) done10_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    vec10_t m;

    // Expected issue stream for one full FFT_N=3 run: {A, B, tw, ictrl, stage}.
    tbl[0]  = '{3'd0, 3'd4, 2'd0, 2'b01, 2'd0};
    tbl[1]  = '{3'd1, 3'd5, 2'd1, 2'b00, 2'd0};
    tbl[2]  = '{3'd2, 3'd6, 2'd2, 2'b00, 2'd0};
    tbl[3]  = '{3'd3, 3'd7, 2'd3, 2'b10, 2'd0};
    tbl[4]  = '{3'd0, 3'd2, 2'd0, 2'b01, 2'd1};
    tbl[5]  = '{3'd1, 3'd3, 2'd2, 2'b00, 2'd1};
    tbl[6]  = '{3'd4, 3'd6, 2'd0, 2'b00, 2'd1};
    tbl[7]  = '{3'd5, 3'd7, 2'd2, 2'b10, 2'd1};
    tbl[8]  = '{3'd0, 3'd1, 2'd0, 2'b01, 2'd2};
    tbl[9]  = '{3'd2, 3'd3, 2'd0, 2'b00, 2'd2};
    tbl[10] = '{3'd4, 3'd5, 2'd0, 2'b00, 2'd2};
    tbl[11] = '{3'd6, 3'd7, 2'd0, 2'b10, 2'd2};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_iact", iact3, 1'b0);
    check("rst_ictrl", ictrl3, 2'b00);
    check("rst_addr_a", a3, 3'd0);
    check("rst_addr_b", b3, 3'd0);
    check("rst_tw_addr", tw3, 2'd0);
    check("rst_stage", stage3, 2'd0);
    check("rst_busy", busy3, 1'b0);
    check("rst_done", done3, 1'b0);
    rst3 = 1'b0;
    rst10 = 1'b0;

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst3 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    check("rst_over_start_busy", busy3, 1'b0);
    rst3 = 1'b0; start3 = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_rst_start", busy3, 1'b0);

    // Plain full run.
    pulse_start3();
    check("busy_after_start", busy3, 1'b1);
    run_to_done("basic");

    // Two-cycle hold after the second stage0 issue.
    pulse_start3();
    n = 0;
    for (int k = 0; k < 50 && n < 2; k++) begin
      @(negedge clk);
      if (iact3) n++;
    end
    check("hold_reached_issue2", n, 2);
    hold3 = 1'b1;
    @(negedge clk);
    check("hold_gap_cycle1", iact3, 1'b0);
    @(negedge clk);
    check("hold_gap_cycle2", iact3, 1'b0);
    hold3 = 1'b0;
    @(negedge clk);
    check("hold_resume_issue", iact3, 1'b1);
    run_to_done("hold");

    // Returns withheld for 20 cycles after the last stage0 issue.
    base = oact_cnt;
    pulse_start3();
    n = 0;
    for (int k = 0; k < 50 && n < 4; k++) begin
      @(negedge clk);
      if (iact3) n++;
    end
    check("withhold_reached_issue4", n, 4);
    withhold = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("drain_wait_iact_busy_stage", {iact3, busy3, stage3}, {1'b0, 1'b1, 2'd0});
    end
    withhold = 1'b0;
    n = 0;
    for (int k = 0; k < 12 && n == 0; k++) begin
      @(negedge clk);
      if (iact3) n = 1;
    end
    check("stage1_started", n, 1);
    check("stage1_after_4_returns", oact_cnt - base, 4);
    check("stage1_issue_latency", cyc - last_oact_cyc, 2);
    run_to_done("withhold");

    // start pulsed during stage1 is ignored.
    pulse_start3();
    n = 0;
    for (int k = 0; k < 60 && n == 0; k++) begin
      @(negedge clk);
      if (stage3 == 2'd1) n = 1;
    end
    check("reached_stage1", n, 1);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("start_ignored_stage", stage3, 2'd1);
    run_to_done("start_ignored");

    // Reset in stage1 DRAIN, then a clean rerun.
    pulse_start3();
    n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk);
      if (iact3 && stage3 == 2'd1) n++;
    end
    check("reached_stage1_drain", n, 4);
    rst3 = 1'b1;
    @(negedge clk);
    check("mid_rst_busy_stage_iact", {busy3, stage3, iact3}, 4'b0);
    @(negedge clk);
    rst3 = 1'b0;
    sb3.delete();
    @(negedge clk);
    pulse_start3();
    run_to_done("after_rst");

    // FFT_N=10 smoke run against a grouped-butterfly model.
    for (int s = 0; s < 10; s++) begin
      for (int j = 0; j < 512; j++) begin
        int span;
        int k;
        span    = 1 << (9 - s);
        k       = j % span;
        m.a     = 10'((j / span) * 2 * span + k);
        m.b     = 10'((j / span) * 2 * span + k + span);
        m.tw    = 9'(k << s);
        m.ictrl = {(j == 511), (j == 0)};
        m.stage = 4'(s);
        sb10.push_back(m);
      end
    end
    start10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    for (int k = 0; k < 8000 && done10_cnt == 0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("n10_one_done", done10_cnt, 1);
    check("n10_issue_count", iss10, 5120);
    check("n10_stage9_tw_zero", tw9_nonzero, 0);
    check("n10_busy_dropped", busy10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
